// File: rtl/hbm_req_arbiter.sv
// Round-robin arbiter funnelling several requesters onto one HBM pseudo-channel
// command port, with calibration gating and an outstanding-command limiter.
module hbm_req_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 33,
    parameter int LEN_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            init_done_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            cmd_valid_o,
    input  logic                            cmd_ready_i,
    output logic                            cmd_we_o,
    output logic [ADDR_WIDTH-1:0]           cmd_addr_o,
    output logic [LEN_WIDTH-1:0]            cmd_len_o,
    output logic [SRC_W-1:0]                cmd_src_o,
    input  logic                            done_i,
    output logic [3:0]                      outstanding_o,
    output logic                            busy_o,
    output logic                            err_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic [3:0]             r_outstanding;
    logic                   r_err;
    logic                   r_cmd_valid;
    logic                   r_cmd_we;
    logic [ADDR_WIDTH-1:0]  r_cmd_addr;
    logic [LEN_WIDTH-1:0]   r_cmd_len;
    logic [SRC_W-1:0]       r_cmd_src;

    logic                   w_any;
    logic [SRC_W-1:0]       w_gnt_idx;
    logic                   w_room;
    logic                   w_grant;
    logic                   w_hs;
    logic [NUM_REQ-1:0]     w_ready;

    assign w_room = (r_outstanding < 4'(MAX_OUTSTANDING));
    assign w_hs   = r_cmd_valid & cmd_ready_i;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        int idx;
        w_any     = 1'b0;
        w_gnt_idx = {SRC_W{1'b0}};
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_any && req_valid_i[idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = SRC_W'(idx);
            end else begin
                w_any     = w_any;
            end
        end
    end

    // Next-state and grant decode.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (init_done_i) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_INIT;
            end
            ST_IDLE: begin
                if (!init_done_i) begin
                    w_state_nxt = ST_INIT;
                end else if (w_any && w_room) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            // A command already granted completes even if calibration drops.
            ST_ISSUE: begin
                if (cmd_ready_i) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_ISSUE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // One-hot acceptance strobe for the granted requester.
    always_comb begin
        w_ready = {NUM_REQ{1'b0}};
        if (w_grant) w_ready[w_gnt_idx] = 1'b1;
        else         w_ready = {NUM_REQ{1'b0}};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_nxt;
    end

    // Command capture on grant, held until the address-channel handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= {ADDR_WIDTH{1'b0}};
            r_cmd_len   <= {LEN_WIDTH{1'b0}};
            r_cmd_src   <= {SRC_W{1'b0}};
            r_rr_ptr    <= {SRC_W{1'b0}};
        end else if (w_grant) begin
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= req_we_i[w_gnt_idx];
            r_cmd_addr  <= req_addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_cmd_len   <= req_len_i[w_gnt_idx*LEN_WIDTH +: LEN_WIDTH];
            r_cmd_src   <= w_gnt_idx;
        end else if (w_hs) begin
            r_cmd_valid <= 1'b0;
            r_rr_ptr    <= (r_cmd_src == SRC_W'(NUM_REQ - 1)) ? {SRC_W{1'b0}}
                                                              : r_cmd_src + 1'b1;
        end
    end

    // Outstanding counter; a completion with nothing in flight is flagged sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= 4'd0;
            r_err         <= 1'b0;
        end else begin
            case ({w_hs, done_i})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01: begin
                    if (r_outstanding == 4'd0) r_err <= 1'b1;
                    else                       r_outstanding <= r_outstanding - 4'd1;
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign req_ready_o   = w_ready;
    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_we_o      = r_cmd_we;
    assign cmd_addr_o    = r_cmd_addr;
    assign cmd_len_o     = r_cmd_len;
    assign cmd_src_o     = r_cmd_src;
    assign outstanding_o = r_outstanding;
    assign busy_o        = (r_outstanding != 4'd0);
    assign err_o         = r_err;

endmodule
